mitchell_log_encoder_pipe: RTL and testbench
============================================

Name: mitchell_log_encoder_pipe

Overview:
Multi-lane, pipelined Mitchell logarithm front end. Per lane it converts an A_BW-bit operand into characteristic k (leading-one position), a truncated left-aligned mantissa fraction, a zero flag and an optional sign. It sits between the operand buffers and the approximate multiplier/adder datapath, with valid/ready handshakes and full backpressure.

Parameters:
A_BW, 16, operand width per lane (>=4)
LANES, 4, number of independent lanes processed in parallel
FRAC_BW, 8, mantissa fraction bits kept (1..A_BW); truncation, no rounding
SIGNED, 0, 1 = operands are two's complement; magnitude is encoded and sign is reported
KW, $clog2(A_BW), derived width of k (localparam, not overridable)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_data  in  LANES*A_BW  lane i at [i*A_BW +: A_BW]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
out_k  out  LANES*KW  characteristic per lane
out_frac  out  LANES*FRAC_BW  mantissa fraction per lane
out_zero  out  LANES  lane operand was zero
out_sign  out  LANES  lane operand negative (always 0 when SIGNED=0)

Behaviour:
- Reset (async assert, sync release on clk): s1_valid=0, s2_valid=0, all output registers 0; in_ready=1 after reset.
- Per-lane math: m = SIGNED ? |A| : A (|-2^(A_BW-1)| = 2^(A_BW-1), fits unsigned A_BW); k = index of highest set bit of m; x = m << (A_BW-k) truncated to A_BW bits (leading one discarded); frac = x[A_BW-1 -: FRAC_BW].
- Zero lane: out_zero=1, k=0, frac=0, sign=0. m=1: k=0, frac=0, zero=0 (distinguished only by out_zero).
- Pipeline: stage 1 registers magnitude, sign, zero and k (LOD + priority encode). Stage 2 registers shifted/truncated frac plus forwarded k/zero/sign. Latency 2 cycles from accepted input to out_valid; throughput 1 beat/cycle.
- Handshake: beat accepted when in_valid & in_ready; emitted when out_valid & out_ready. s2_load = ~s2_valid | out_ready; s1 advances into s2 when s2_load; in_ready = ~s1_valid | s2_load (combinational from out_ready, no combinational path from in_valid).
- Stall: while out_valid & ~out_ready, all out_* hold stable; no beat dropped or duplicated; with both stages full, in_ready=0.
- Simultaneous accept and emit on a full pipe: both stages shift, no bubble.
- Pipeline registers never load without the corresponding valid; data regs updated only on load.
- Reset mid-operation: in-flight beats discarded, valids cleared immediately (async).

Decomposition:
- Package mitchell_pkg: function clog2-based KW helper, lane slice macros/functions, FRAC truncation helper; shared with the existing pre-approximation and multiplier blocks.
- Sub-module mitchell_lane_log: combinational per-lane magnitude, LOD, priority encode, normalise shift; instantiated LANES times via generate, split at the stage-1/stage-2 boundary (k stage, shift stage).

Test Plan:
- Unsigned, A_BW=16, FRAC_BW=8, lane0=0x00B4 -> after 2 cycles out_k=7, out_frac=0x68, zero=0, sign=0; lane1=0xFFFF -> k=15, frac=0xFF; lane2=0x0001 -> k=0, frac=0x00, zero=0; lane3=0x0000 -> k=0, frac=0, zero=1.
- SIGNED=1: lane0=0xFF4C (-180) -> sign=1, k=7, frac=0x68; lane1=0x8000 -> sign=1, k=15, frac=0x00; lane2=0x7FFF -> sign=0, k=14, frac=0xFF.
- Streaming: in_valid high 20 cycles, out_ready high -> 20 outputs, first at cycle 2, in order, in_ready never drops.
- Backpressure: out_ready low 5 cycles during stream -> in_ready falls after 2 beats buffered, out_* stable, resume gives exact in-order sequence, no loss/duplication.
- Random out_ready/in_valid, 10k beats vs reference model of the lane math -> zero mismatches; FRAC_BW=16 run checks right zero padding (0x00B4 -> frac=0x6800).
- Assert rst with 2 beats in flight -> out_valid=0 immediately, outputs 0, first post-reset beat emerges at latency 2 with correct values.

Source files
------------

// File: rtl/mitchell_pkg.sv
// Shared helpers for the Mitchell logarithm blocks: characteristic width,
// lane slicing and normalisation shift amount.
package mitchell_pkg;

  function automatic int kw_of(input int a_bw);
    return (a_bw <= 1) ? 1 : $clog2(a_bw);
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Shifting by (width - k) pushes the leading one out of the top bit,
  // leaving only the fraction bits left-aligned.
  function automatic int norm_shift(input int a_bw, input int k);
    return a_bw - k;
  endfunction

endpackage

// File: rtl/mitchell_lane_log.sv
// Per-lane combinational Mitchell log front end, split at the pipeline cut:
// the k half (magnitude, sign, zero, leading-one) and the shift half (fraction).
module mitchell_lane_log
  import mitchell_pkg::*;
#(
  parameter int A_BW    = 16,
  parameter int FRAC_BW = 8,
  parameter int SIGNED  = 0,
  parameter int KW      = 4
) (
  input  logic [A_BW-1:0]    operand,
  output logic [A_BW-1:0]    mag,
  output logic               sign,
  output logic               zero,
  output logic [KW-1:0]      k,
  input  logic [A_BW-1:0]    mag_q,
  input  logic [KW-1:0]      k_q,
  output logic [FRAC_BW-1:0] frac
);

  logic [A_BW-1:0] norm;

  // The most negative value negates to itself, which read unsigned is the
  // correct magnitude 2^(A_BW-1).
  always_comb begin
    sign = (SIGNED != 0) && operand[A_BW-1];
    mag  = sign ? (~operand + A_BW'(1)) : operand;
    zero = (mag == '0);
    k    = '0;
    for (int i = 0; i < A_BW; i++) begin
      if (mag[i]) k = KW'(i);
    end
  end

  always_comb begin
    norm = mag_q << norm_shift(A_BW, int'(k_q));
    frac = FRAC_BW'(norm >> (A_BW - FRAC_BW));
  end

endmodule

// File: rtl/mitchell_log_encoder_pipe.sv
// Multi-lane two-stage Mitchell log encoder with valid/ready flow control:
// stage 1 holds magnitude/sign/zero/k, stage 2 holds the truncated fraction.
module mitchell_log_encoder_pipe
  import mitchell_pkg::*;
#(
  parameter int A_BW    = 16,
  parameter int LANES   = 4,
  parameter int FRAC_BW = 8,
  parameter int SIGNED  = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [LANES*A_BW-1:0]              in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES*kw_of(A_BW)-1:0]       out_k,
  output logic [LANES*FRAC_BW-1:0]           out_frac,
  output logic [LANES-1:0]                   out_zero,
  output logic [LANES-1:0]                   out_sign
);

  localparam int KW = kw_of(A_BW);

  logic                s1_valid;
  logic                s2_valid;
  logic                s2_load;
  logic [A_BW-1:0]     s1_mag  [LANES];
  logic [KW-1:0]       s1_k    [LANES];
  logic [LANES-1:0]    s1_sign;
  logic [LANES-1:0]    s1_zero;
  logic [KW-1:0]       s2_k    [LANES];
  logic [FRAC_BW-1:0]  s2_frac [LANES];
  logic [LANES-1:0]    s2_sign;
  logic [LANES-1:0]    s2_zero;
  logic [A_BW-1:0]     c1_mag  [LANES];
  logic [KW-1:0]       c1_k    [LANES];
  logic [LANES-1:0]    c1_sign;
  logic [LANES-1:0]    c1_zero;
  logic [FRAC_BW-1:0]  c2_frac [LANES];

  // Stage 2 frees up when empty or draining; stage 1 can then shift forward,
  // so in_ready depends on out_ready but never on in_valid.
  assign s2_load   = ~s2_valid | out_ready;
  assign in_ready  = ~s1_valid | s2_load;
  assign out_valid = s2_valid;
  assign out_zero  = s2_zero;
  assign out_sign  = s2_sign;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mitchell_lane_log #(
      .A_BW    (A_BW),
      .FRAC_BW (FRAC_BW),
      .SIGNED  (SIGNED),
      .KW      (KW)
    ) u_lane (
      .operand (in_data[lane_lsb(g, A_BW) +: A_BW]),
      .mag     (c1_mag[g]),
      .sign    (c1_sign[g]),
      .zero    (c1_zero[g]),
      .k       (c1_k[g]),
      .mag_q   (s1_mag[g]),
      .k_q     (s1_k[g]),
      .frac    (c2_frac[g])
    );

    assign out_k[lane_lsb(g, KW) +: KW]           = s2_k[g];
    assign out_frac[lane_lsb(g, FRAC_BW) +: FRAC_BW] = s2_frac[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= '0;
      s1_zero  <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_mag[i] <= '0;
        s1_k[i]   <= '0;
      end
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_sign <= c1_sign;
        s1_zero <= c1_zero;
        for (int i = 0; i < LANES; i++) begin
          s1_mag[i] <= c1_mag[i];
          s1_k[i]   <= c1_k[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= '0;
      s2_zero  <= '0;
      for (int i = 0; i < LANES; i++) begin
        s2_k[i]    <= '0;
        s2_frac[i] <= '0;
      end
    end else begin
      if (s2_load) s2_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        s2_sign <= s1_sign;
        s2_zero <= s1_zero;
        for (int i = 0; i < LANES; i++) begin
          s2_k[i]    <= s1_k[i];
          s2_frac[i] <= c2_frac[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_mitchell_log_encoder_pipe.sv
// Scoreboard bench for mitchell_log_encoder_pipe: an unsigned FRAC_BW=8 and a
// signed FRAC_BW=16 instance share stimulus and are checked against a log2 model.
module tb_mitchell_log_encoder_pipe;

  localparam int A_BW  = 16;
  localparam int LANES = 4;
  localparam int KW    = 4;

  typedef struct {
    logic [LANES*KW-1:0] k;
    logic [63:0]         frac;
    logic [LANES-1:0]    zero;
    logic [LANES-1:0]    sign;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  out_ready = 1'b0;
  logic [LANES*A_BW-1:0] in_data = '0;

  logic                  in_ready_a, out_valid_a;
  logic [LANES*KW-1:0]   out_k_a;
  logic [LANES*8-1:0]    out_frac_a;
  logic [LANES-1:0]      out_zero_a, out_sign_a;

  logic                  in_ready_b, out_valid_b;
  logic [LANES*KW-1:0]   out_k_b;
  logic [LANES*16-1:0]   out_frac_b;
  logic [LANES-1:0]      out_zero_b, out_sign_b;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mitchell_log_encoder_pipe #(.A_BW(A_BW), .LANES(LANES), .FRAC_BW(8), .SIGNED(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_k(out_k_a), .out_frac(out_frac_a),
    .out_zero(out_zero_a), .out_sign(out_sign_a)
  );

  mitchell_log_encoder_pipe #(.A_BW(A_BW), .LANES(LANES), .FRAC_BW(16), .SIGNED(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_k(out_k_b), .out_frac(out_frac_b),
    .out_zero(out_zero_b), .out_sign(out_sign_b)
  );

  // Reference: k = floor(log2 m), frac = (m/2^k - 1) * 2^fbw truncated.
  function automatic exp_t model(input logic [LANES*A_BW-1:0] d, input bit sgn, input int fbw);
    exp_t e;
    e.k = '0; e.frac = '0; e.zero = '0; e.sign = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [15:0] v;
      longint m, f;
      int kk;
      v = d[l*A_BW +: A_BW];
      m = (sgn && v[15]) ? (longint'(65536) - longint'(v)) : longint'(v);
      if (m == 0) begin
        e.zero[l] = 1'b1;
      end else begin
        kk = 0;
        while ((m >> (kk + 1)) != 0) kk++;
        f = ((m - (longint'(1) << kk)) << fbw) >> kk;
        e.k[l*KW +: KW] = KW'(kk);
        e.frac = e.frac | (64'(f) << (l * fbw));
        e.sign[l] = sgn && v[15];
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] rndLane();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h0001;
      default: return 16'($urandom) >> $urandom_range(0, 15);
    endcase
  endfunction

  function automatic logic [LANES*A_BW-1:0] rndBeat();
    logic [LANES*A_BW-1:0] d;
    for (int l = 0; l < LANES; l++) d[l*A_BW +: A_BW] = rndLane();
    return d;
  endfunction

  // Queue depth equals pipeline occupancy, so in_ready is predictable from it.
  task automatic applyStimulus(input logic v, input logic [LANES*A_BW-1:0] d, input logic r);
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = r;
    #1;
    checkOutput("in_ready_a", 128'(in_ready_a), 128'(r || qa.size() < 2));
    checkOutput("in_ready_b", 128'(in_ready_b), 128'(r || qb.size() < 2));
    if (v && in_ready_a) qa.push_back(model(d, 1'b0, 8));
    if (v && in_ready_b) qb.push_back(model(d, 1'b1, 16));
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
      applyStimulus(1'b0, '0, 1'b1);
      n++;
    end
    checkOutput("drain_a", 128'(qa.size()), 128'(0));
    checkOutput("drain_b", 128'(qb.size()), 128'(0));
  endtask

  task automatic measureLatency(input logic [LANES*A_BW-1:0] d);
    int cyc;
    applyStimulus(1'b1, d, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid_a && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("latency", 128'(cyc), 128'(2));
  endtask

  task automatic checkResetState();
    checkOutput("rst_out_a", {out_valid_a, out_k_a, out_frac_a, out_zero_a, out_sign_a}, '0);
    checkOutput("rst_out_b", {out_valid_b, out_k_b, out_frac_b, out_zero_b, out_sign_b}, '0);
    checkOutput("rst_in_ready", {in_ready_a, in_ready_b}, 128'b11);
  endtask

  initial begin : mon_a
    logic       held = 1'b0;
    logic [127:0] snap = '0;
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) checkOutput("hold_a", {out_valid_a, out_k_a, out_frac_a, out_zero_a, out_sign_a}, snap);
        if (out_valid_a && out_ready) begin
          if (qa.size() == 0) begin
            checkOutput("extra_a", 128'(1), 128'(0));
          end else begin
            e = qa.pop_front();
            checkOutput("k_a", 128'(out_k_a), 128'(e.k));
            checkOutput("frac_a", 128'(out_frac_a), 128'(e.frac));
            checkOutput("zero_a", 128'(out_zero_a), 128'(e.zero));
            checkOutput("sign_a", 128'(out_sign_a), 128'(e.sign));
          end
        end
        held = out_valid_a && !out_ready;
        snap = {out_valid_a, out_k_a, out_frac_a, out_zero_a, out_sign_a};
      end
    end
  end

  initial begin : mon_b
    logic       held = 1'b0;
    logic [127:0] snap = '0;
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) checkOutput("hold_b", {out_valid_b, out_k_b, out_frac_b, out_zero_b, out_sign_b}, snap);
        if (out_valid_b && out_ready) begin
          if (qb.size() == 0) begin
            checkOutput("extra_b", 128'(1), 128'(0));
          end else begin
            e = qb.pop_front();
            checkOutput("k_b", 128'(out_k_b), 128'(e.k));
            checkOutput("frac_b", 128'(out_frac_b), 128'(e.frac));
            checkOutput("zero_b", 128'(out_zero_b), 128'(e.zero));
            checkOutput("sign_b", 128'(out_sign_b), 128'(e.sign));
          end
        end
        held = out_valid_b && !out_ready;
        snap = {out_valid_b, out_k_b, out_frac_b, out_zero_b, out_sign_b};
      end
    end
  end

  initial begin
    #3;
    checkResetState();
    @(posedge clk); #3;
    rst = 1'b0;

    $display("[TB] directed vectors");
    measureLatency({16'h0000, 16'h0001, 16'hFFFF, 16'h00B4});
    drain();
    applyStimulus(1'b1, {16'h1234, 16'h7FFF, 16'h8000, 16'hFF4C}, 1'b1);
    applyStimulus(1'b1, {16'h00B4, 16'h0002, 16'h0003, 16'h4000}, 1'b1);
    drain();

    $display("[TB] streaming");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, rndBeat(), 1'b1);
    drain();

    $display("[TB] backpressure");
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, rndBeat(), !(i >= 3 && i < 8));
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 10000; i++)
      applyStimulus($urandom_range(0, 3) != 0, rndBeat(), $urandom_range(0, 3) != 0);
    drain();

    $display("[TB] reset with beats in flight");
    applyStimulus(1'b1, rndBeat(), 1'b1);
    applyStimulus(1'b1, rndBeat(), 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkResetState();
    qa.delete();
    qb.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    measureLatency({16'h0000, 16'h0001, 16'hFFFF, 16'h00B4});
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
